// File: rtl/div16x8_if.sv
// Request/result bundle for div16x8: operands with start, registered results with status.
// The master drives the request and the slave returns the results.
interface div16x8_if;
   logic        start;
   logic [15:0] dividend;
   logic [7:0]  divisor;
   logic [15:0] quotient;
   logic [7:0]  remainder;
   logic        busy;
   logic        done;
   logic        err;

   modport master (
      output start, dividend, divisor,
      input  quotient, remainder, busy, done, err
   );

   modport slave (
      input  start, dividend, divisor,
      output quotient, remainder, busy, done, err
   );
endinterface

// File: rtl/div16x8.sv
// 16/8 unsigned restoring divider, one quotient bit per cycle, 18-cycle throughput.
// Optional macro DIV_ZERO_DETECT_EN: short-circuit divisor==0 straight to DONE and raise err.
module div16x8 (
   input  logic      clk,
   input  logic      sclr,
   div16x8_if.slave  bus
);

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t      state, state_nxt;
   logic [15:0] dvd_q;        // dividend shifts out MSB first, quotient bits shift in at LSB
   logic [7:0]  dvs_q;
   logic [7:0]  rem_q;
   logic [3:0]  cnt_q;
   logic [15:0] quotient_q;
   logic [7:0]  remainder_q;
   logic        busy_q;
   logic        done_q;
   logic        zero_hit;
   logic [8:0]  rem_shift;
   logic        rem_ge;
   logic [7:0]  rem_sub;

`ifdef DIV_ZERO_DETECT_EN
   assign zero_hit = (bus.divisor == 8'd0);
`else
   assign zero_hit = 1'b0;
`endif

   // The shifted remainder needs 9 bits; after a subtract it always fits back into 8.
   always_comb begin
      rem_shift = {rem_q, dvd_q[15]};
      rem_ge    = (rem_shift >= {1'b0, dvs_q});
      rem_sub   = rem_shift[7:0] - dvs_q;
   end

   always_ff @(posedge clk) begin
      if (sclr) state <= IDLE;
      else      state <= state_nxt;
   end

   // NOTE: combinational logic uses blocking '=' with a default first so no latch is inferred;
   // clocked state uses non-blocking '<=' so all registers update from pre-edge values.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (bus.start) state_nxt = zero_hit ? DONE : CALC;
         CALC: if (cnt_q == 4'd0) state_nxt = DONE;
         DONE: state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (sclr) begin
         dvd_q       <= '0;
         dvs_q       <= '0;
         rem_q       <= '0;
         cnt_q       <= '0;
         quotient_q  <= '0;
         remainder_q <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.start) begin
                  dvs_q  <= bus.divisor;
                  cnt_q  <= 4'd15;
                  busy_q <= 1'b1;
                  if (zero_hit) begin
                     dvd_q <= 16'hFFFF;
                     rem_q <= bus.dividend[7:0];
                  end else begin
                     dvd_q <= bus.dividend;
                     rem_q <= '0;
                  end
               end
            end
            CALC: begin
               rem_q <= rem_ge ? rem_sub : rem_shift[7:0];
               dvd_q <= {dvd_q[14:0], rem_ge};
               cnt_q <= cnt_q - 4'd1;
            end
            DONE: begin
               quotient_q  <= dvd_q;
               remainder_q <= rem_q;
               busy_q      <= 1'b0;
               done_q      <= 1'b1;
            end
            default: ;
         endcase
      end
   end

`ifdef DIV_ZERO_DETECT_EN
   logic zflag_q;
   logic err_q;

   always_ff @(posedge clk) begin
      if (sclr) begin
         zflag_q <= 1'b0;
         err_q   <= 1'b0;
      end else if (state == IDLE && bus.start) begin
         zflag_q <= zero_hit;
      end else if (state == DONE) begin
         err_q   <= zflag_q;
      end
   end

   assign bus.err = err_q;
`else
   assign bus.err = 1'b0;
`endif

   assign bus.quotient  = quotient_q;
   assign bus.remainder = remainder_q;
   assign bus.busy      = busy_q;
   assign bus.done      = done_q;

endmodule
